matmul_seq: RTL and testbench

- Sequencer that computes C = A x B on one shared multiply-accumulate unit instead of a fully parallel array.
- Latches packed 8-bit operand matrices on a start handshake and walks i/j/k indices with a state machine.
- Accumulates each dot product, writes it into a packed result register, then pulses done.
- Sits between the matrix-multiply testbench/top and the MAC datapath; it is the controller for the matrix datapath.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/mac_unit.sv | 36 +++
 rtl/matmul_seq.sv | 150 +++++++++++++++
 tb/tb_matmul_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Holds the controller state encoding, default widths and packed-element offset math.
package matmul_pkg;

    localparam int ELEM_W_DEF = 8;
    localparam int RES_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Element 0 sits in the MSBs, so offsets count down from the top of the vector.
    function automatic int elemOffset(input int n, input int count, input int width);
        return (count - 1 - n) * width;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Single multiply-accumulate register shared by every dot product.
// Clear has priority over enable so a new dot product can start on the same edge.
module mac_unit
    import matmul_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [RES_W-1:0]  acc
);

    logic [2*ELEM_W-1:0] prod;
    logic [RES_W-1:0]    acc_q;

    assign prod = {{ELEM_W{1'b0}}, a} * {{ELEM_W{1'b0}}, b};

    // Product is resized to the accumulator width; the sum wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + RES_W'(prod);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matmul_seq.sv
// Controller that computes C = A x B one product per cycle through a shared MAC.
// Walks i/j/k over latched operands and publishes the whole result matrix at once.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int A_ROW  = 3,
    parameter int A_COL  = 2,
    parameter int B_COL  = 3,
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int RES_W  = RES_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [A_ROW*A_COL*ELEM_W-1:0] a_in,
    input  logic [A_COL*B_COL*ELEM_W-1:0] b_in,
    output logic                         busy,
    output logic                         done,
    output logic [A_ROW*B_COL*RES_W-1:0]  res_out
);

    localparam int A_BITS = A_ROW * A_COL * ELEM_W;
    localparam int B_BITS = A_COL * B_COL * ELEM_W;
    localparam int C_BITS = A_ROW * B_COL * RES_W;
    localparam int IW = (A_ROW > 1) ? $clog2(A_ROW) : 1;
    localparam int JW = (B_COL > 1) ? $clog2(B_COL) : 1;
    localparam int KW = (A_COL > 1) ? $clog2(A_COL) : 1;

    state_e            state_q, state_d;
    logic [IW-1:0]     rowIdx_q, rowIdx_d;
    logic [JW-1:0]     colIdx_q, colIdx_d;
    logic [KW-1:0]     kIdx_q, kIdx_d;
    logic [A_BITS-1:0] aLatched_q, aLatched_d;
    logic [B_BITS-1:0] bLatched_q, bLatched_d;
    logic [C_BITS-1:0] result_q, result_d;
    logic [C_BITS-1:0] resOut_q, resOut_d;
    logic [C_BITS-1:0] cWritten;
    logic [ELEM_W-1:0] aElem, bElem;
    logic [RES_W-1:0]  macAcc;
    logic              macClr, macEn;
    int                aOff, bOff, cOff;

    mac_unit #(
        .ELEM_W (ELEM_W),
        .RES_W  (RES_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (macClr),
        .en  (macEn),
        .a   (aElem),
        .b   (bElem),
        .acc (macAcc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rowIdx_q   <= '0;
            colIdx_q   <= '0;
            kIdx_q     <= '0;
            aLatched_q <= '0;
            bLatched_q <= '0;
            result_q   <= '0;
            resOut_q   <= '0;
        end else begin
            state_q    <= state_d;
            rowIdx_q   <= rowIdx_d;
            colIdx_q   <= colIdx_d;
            kIdx_q     <= kIdx_d;
            aLatched_q <= aLatched_d;
            bLatched_q <= bLatched_d;
            result_q   <= result_d;
            resOut_q   <= resOut_d;
        end
    end

    // Operand selection and the result matrix with the current accumulator merged in.
    always_comb begin
        aOff     = elemOffset(int'(rowIdx_q) * A_COL + int'(kIdx_q), A_ROW * A_COL, ELEM_W);
        bOff     = elemOffset(int'(kIdx_q) * B_COL + int'(colIdx_q), A_COL * B_COL, ELEM_W);
        cOff     = elemOffset(int'(rowIdx_q) * B_COL + int'(colIdx_q), A_ROW * B_COL, RES_W);
        aElem    = ELEM_W'(aLatched_q >> aOff);
        bElem    = ELEM_W'(bLatched_q >> bOff);
        cWritten = (result_q & ~(C_BITS'({RES_W{1'b1}}) << cOff)) | (C_BITS'(macAcc) << cOff);
    end

    always_comb begin
        state_d    = state_q;
        rowIdx_d   = rowIdx_q;
        colIdx_d   = colIdx_q;
        kIdx_d     = kIdx_q;
        aLatched_d = aLatched_q;
        bLatched_d = bLatched_q;
        result_d   = result_q;
        resOut_d   = resOut_q;
        macClr     = 1'b0;
        macEn      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    aLatched_d = a_in;
                    bLatched_d = b_in;
                    rowIdx_d   = '0;
                    colIdx_d   = '0;
                    kIdx_d     = '0;
                    macClr     = 1'b1;
                    state_d    = ST_MAC;
                end
            end
            ST_MAC: begin
                macEn = 1'b1;
                if (kIdx_q == KW'(A_COL - 1)) begin
                    state_d = ST_WRITE;
                end else begin
                    kIdx_d = kIdx_q + 1'b1;
                end
            end
            ST_WRITE: begin
                macClr   = 1'b1;
                result_d = cWritten;
                kIdx_d   = '0;
                state_d  = ST_MAC;
                if (colIdx_q == JW'(B_COL - 1)) begin
                    colIdx_d = '0;
                    if (rowIdx_q == IW'(A_ROW - 1)) begin
                        rowIdx_d = '0;
                        resOut_d = cWritten;
                        state_d  = ST_DONE;
                    end else begin
                        rowIdx_d = rowIdx_q + 1'b1;
                    end
                end else begin
                    colIdx_d = colIdx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q == ST_MAC) || (state_q == ST_WRITE);
    assign done    = (state_q == ST_DONE);
    assign res_out = resOut_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: fixed vectors, random runs against a plain
// matrix-product model, and hand-written abort / busy / back-to-back sequences.
module tb_matmul_seq;

    localparam int A_ROW  = 3;
    localparam int A_COL  = 2;
    localparam int B_COL  = 3;
    localparam int ELEM_W = 8;
    localparam int RES_W  = 16;
    localparam int A_BITS = A_ROW * A_COL * ELEM_W;
    localparam int B_BITS = A_COL * B_COL * ELEM_W;
    localparam int C_BITS = A_ROW * B_COL * RES_W;
    localparam int LAT    = A_ROW * B_COL * (A_COL + 1) + 1;
    localparam int WINDOW = 40;

    typedef struct {
        string             name;
        logic [A_BITS-1:0] a;
        logic [B_BITS-1:0] b;
        logic [C_BITS-1:0] c;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [A_BITS-1:0] a_in = '0;
    logic [B_BITS-1:0] b_in = '0;
    logic              busy;
    logic              done;
    logic [C_BITS-1:0] res_out;

    int total = 0;
    int bad   = 0;
    vec_t vecs[3];

    matmul_seq #(
        .A_ROW  (A_ROW),
        .A_COL  (A_COL),
        .B_COL  (B_COL),
        .ELEM_W (ELEM_W),
        .RES_W  (RES_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .res_out (res_out)
    );

    always #5 clk = ~clk;

    // C[r][c] = sum over k of A[r][k]*B[k][c], reduced mod 2^RES_W.
    function automatic logic [C_BITS-1:0] refModel(input logic [A_BITS-1:0] a, input logic [B_BITS-1:0] b);
        logic [C_BITS-1:0] c;
        int ma[A_ROW][A_COL];
        int mb[A_COL][B_COL];
        longint sum;
        c = '0;
        for (int r = 0; r < A_ROW; r++)
            for (int k = 0; k < A_COL; k++)
                ma[r][k] = int'(a[(A_ROW*A_COL-1-(r*A_COL+k))*ELEM_W +: ELEM_W]);
        for (int k = 0; k < A_COL; k++)
            for (int q = 0; q < B_COL; q++)
                mb[k][q] = int'(b[(A_COL*B_COL-1-(k*B_COL+q))*ELEM_W +: ELEM_W]);
        for (int r = 0; r < A_ROW; r++)
            for (int q = 0; q < B_COL; q++) begin
                sum = 0;
                for (int k = 0; k < A_COL; k++) sum += longint'(ma[r][k]) * longint'(mb[k][q]);
                c[(A_ROW*B_COL-1-(r*B_COL+q))*RES_W +: RES_W] = RES_W'(sum % (longint'(1) << RES_W));
            end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [C_BITS-1:0] act, input logic [C_BITS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One run: pulse start, optionally disturb inputs/start at cycle disturbAt, watch WINDOW cycles.
    task automatic applyStimulus(input logic [A_BITS-1:0] a, input logic [B_BITS-1:0] b,
                                 input int disturbAt, input logic [A_BITS-1:0] a2, input logic [B_BITS-1:0] b2,
                                 output logic [C_BITS-1:0] res, output int doneAt, output int doneCount,
                                 output int busyErrs);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        doneAt    = -1;
        doneCount = 0;
        busyErrs  = 0;
        res       = '0;
        for (int cyc = 1; cyc <= WINDOW; cyc++) begin
            if (cyc == disturbAt) begin
                a_in  = a2;
                b_in  = b2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt = cyc;
                    res    = res_out;
                end
            end
            if (busy !== (cyc < LAT)) busyErrs++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic runVector(input string name, input logic [A_BITS-1:0] a, input logic [B_BITS-1:0] b,
                             input logic [C_BITS-1:0] exp, input int disturbAt,
                             input logic [A_BITS-1:0] a2, input logic [B_BITS-1:0] b2);
        logic [C_BITS-1:0] res;
        int doneAt, doneCount, busyErrs;
        applyStimulus(a, b, disturbAt, a2, b2, res, doneAt, doneCount, busyErrs);
        checkOutput({name, ".result"}, res, exp);
        checkOutput({name, ".doneCycle"}, C_BITS'(doneAt), C_BITS'(LAT));
        checkOutput({name, ".donePulses"}, C_BITS'(doneCount), C_BITS'(1));
        checkOutput({name, ".busyErrs"}, C_BITS'(busyErrs), '0);
        checkOutput({name, ".hold"}, res_out, exp);
    endtask

    initial begin
        logic [63:0]       ra, rb;
        logic [C_BITS-1:0] r1, r2, exp2;
        logic [A_BITS-1:0] a2;
        logic [B_BITS-1:0] b2;
        int d1, d2, cnt, busyErrs;

        vecs[0] = '{"basic", {8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2}, {6{8'd1}}, {9{16'd3}}};
        vecs[1] = '{"mixed", {8'd1, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3}, {8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9},
                    {16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd29, 16'd34, 16'd39}};
        vecs[2] = '{"overflow", {6{8'd255}}, {6{8'd255}}, {9{16'd64514}}};

        #1 rst = 1'b1;
        #1;
        checkOutput("reset.busy", C_BITS'(busy), '0);
        checkOutput("reset.done", C_BITS'(done), '0);
        checkOutput("reset.res_out", res_out, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++)
            runVector(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, 0, '0, '0);

        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        runVector("busyprot", vecs[1].a, vecs[1].b, vecs[1].c, 10, ra[A_BITS-1:0], rb[B_BITS-1:0]);

        for (int i = 0; i < 10; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            runVector($sformatf("rand%0d", i), ra[A_BITS-1:0], rb[B_BITS-1:0],
                      refModel(ra[A_BITS-1:0], rb[B_BITS-1:0]), 0, '0, '0);
        end

        // Abort at cycle 15 of a run with a non-zero result already published.
        runVector("preabort", vecs[0].a, vecs[0].b, vecs[0].c, 0, '0, '0);
        @(negedge clk);
        a_in  = vecs[1].a;
        b_in  = vecs[1].b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checkOutput("abort.busyBefore", C_BITS'(busy), C_BITS'(1));
        rst = 1'b1;
        #1;
        checkOutput("abort.busy", C_BITS'(busy), '0);
        checkOutput("abort.done", C_BITS'(done), '0);
        checkOutput("abort.res_out", res_out, '0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        busyErrs = 0;
        for (int cyc = 0; cyc < 35; cyc++) begin
            if (done === 1'b1) cnt++;
            if (busy !== 1'b0) busyErrs++;
            @(negedge clk);
        end
        checkOutput("abort.noDone", C_BITS'(cnt), '0);
        checkOutput("abort.idleBusy", C_BITS'(busyErrs), '0);
        checkOutput("abort.resHold", res_out, '0);

        // Start held high: second run picks up new operands in the IDLE cycle after DONE.
        ra   = {$urandom, $urandom};
        rb   = {$urandom, $urandom};
        a2   = ra[A_BITS-1:0];
        b2   = rb[B_BITS-1:0];
        exp2 = refModel(a2, b2);
        @(negedge clk);
        a_in  = vecs[1].a;
        b_in  = vecs[1].b;
        start = 1'b1;
        d1 = -1;
        d2 = -1;
        cnt = 0;
        r1 = '0;
        r2 = '0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cnt++;
                if (cnt == 1) begin
                    d1   = cyc;
                    r1   = res_out;
                    a_in = a2;
                    b_in = b2;
                end else if (cnt == 2) begin
                    d2    = cyc;
                    r2    = res_out;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkOutput("b2b.pulses", C_BITS'(cnt), C_BITS'(2));
        checkOutput("b2b.firstDone", C_BITS'(d1), C_BITS'(LAT));
        checkOutput("b2b.spacing", C_BITS'(d2 - d1), C_BITS'(LAT + 1));
        checkOutput("b2b.result1", r1, vecs[1].c);
        checkOutput("b2b.result2", r2, exp2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
